// File: rtl/lvds_phase_pkg.sv
// Shared types and helpers for the LVDS receiver phase-sweep controller.
//   state_e          : sweep/seek FSM states
//   CNTSEL_OUT0      : PLL counter select used for every phase step (output counter 0)
//   width_in_window  : HSYNC low-width acceptance check
//   eye_centre       : longest circular run of passing phases and its centre
// Optional feature macro used by the controller: LVDS_PHASE_MONITOR_EN.
package lvds_phase_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSettle,
    StMeasure,
    StStepReq,
    StStepAck,
    StNext,
    StSelect,
    StSeek,
    StLocked,
    StError
  } state_e;

  localparam logic [4:0] CNTSEL_OUT0 = 5'b00001;
  localparam int unsigned MaxPhases = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] best;
  } eye_sel_t;

  function automatic logic width_in_window(input logic [9:0] width, input logic [9:0] min_w,
                                           input logic [9:0] max_w);
    return (width >= min_w) && (width <= max_w);
  endfunction

  // Only the low n bits of map are meaningful. Runs wrap from phase n-1 to phase 0; on equal
  // lengths the run with the lowest start index wins because only a strictly longer run replaces
  // the current best.
  function automatic eye_sel_t eye_centre(input logic [MaxPhases-1:0] map, input int unsigned n);
    eye_sel_t   sel;
    logic       all_pass;
    logic       run;
    logic [4:0] idx;
    logic [4:0] prev;
    logic [4:0] best_start;
    logic [5:0] best_len;
    logic [5:0] len;
    sel        = '0;
    all_pass   = 1'b1;
    best_start = '0;
    best_len   = '0;
    for (int unsigned i = 0; i < MaxPhases; i++) begin
      idx = 5'(i);
      if (i < n && !map[idx]) all_pass = 1'b0;
    end
    if (all_pass) begin
      best_len = 6'(n);
    end else begin
      for (int unsigned s = 0; s < MaxPhases; s++) begin
        if (s < n) begin
          idx  = 5'(s);
          prev = 5'((s + n - 1) % n);
          // A run starts where a passing phase follows a failing one.
          if (map[idx] && !map[prev]) begin
            len = '0;
            run = 1'b1;
            for (int unsigned k = 0; k < MaxPhases; k++) begin
              idx = 5'((s + k) % n);
              if (k < n && run) begin
                if (map[idx]) len = len + 6'd1;
                else          run = 1'b0;
              end
            end
            if (len > best_len) begin
              best_len   = len;
              best_start = 5'(s);
            end
          end
        end
      end
    end
    if (best_len != '0) begin
      sel.found = 1'b1;
      sel.best  = 5'((32'(best_start) + (32'(best_len) - 32'd1) / 32'd2) % n);
    end
    return sel;
  endfunction

endpackage

// File: rtl/lvds_hsync_meter.sv
// HSYNC low-pulse width meter.
// Counts low cycles of hsync_n_i (saturating at 1023) while enable_i is high. A pulse is only
// graded if its falling edge was seen while enabled, so a pulse already in progress when the
// meter is enabled is ignored. Strobes are registered (one cycle after the rising edge).
//   clk_i, reset_i  : clock, synchronous active-high reset
//   enable_i        : measure; low clears all meter state
//   hsync_n_i       : recovered HSYNC, active low
//   min_i, max_i    : accepted width window (inclusive)
//   pulse_valid_o   : strobe, a pulse completed
//   pulse_good_o    : with pulse_valid_o, width was inside the window
//   timeout_o       : strobe, LINE_TIMEOUT cycles passed without a completed pulse
module lvds_hsync_meter
  import lvds_phase_pkg::*;
#(
  parameter int unsigned LINE_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       hsync_n_i,
  input  logic [9:0] min_i,
  input  logic [9:0] max_i,
  output logic       pulse_valid_o,
  output logic       pulse_good_o,
  output logic       timeout_o
);

  localparam int unsigned ToW = $clog2(LINE_TIMEOUT + 1);

  logic           hsync_prev_q;
  logic           armed_q, armed_d;
  logic [9:0]     width_q, width_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           valid_q, valid_d;
  logic           good_q, good_d;
  logic           timeout_q, timeout_d;
  logic           to_hit;

  always_comb begin
    armed_d   = armed_q;
    width_d   = width_q;
    to_cnt_d  = to_cnt_q;
    valid_d   = 1'b0;
    good_d    = 1'b0;
    timeout_d = 1'b0;
    to_hit    = (to_cnt_q == ToW'(LINE_TIMEOUT - 1));
    if (!enable_i) begin
      armed_d  = 1'b0;
      width_d  = '0;
      to_cnt_d = '0;
    end else begin
      if (!hsync_n_i) begin
        if (hsync_prev_q) begin
          armed_d = 1'b1;
          width_d = 10'd1;
        end else if (width_q != 10'h3ff) begin
          width_d = width_q + 10'd1;
        end
      end else if (!hsync_prev_q && armed_q) begin
        valid_d = 1'b1;
        good_d  = width_in_window(width_q, min_i, max_i);
        armed_d = 1'b0;
      end
      timeout_d = to_hit && !valid_d;
      if (valid_d || to_hit) to_cnt_d = '0;
      else                   to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hsync_prev_q <= 1'b1;
      armed_q      <= 1'b0;
      width_q      <= '0;
      to_cnt_q     <= '0;
      valid_q      <= 1'b0;
      good_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      hsync_prev_q <= hsync_n_i;
      armed_q      <= armed_d;
      width_q      <= width_d;
      to_cnt_q     <= to_cnt_d;
      valid_q      <= valid_d;
      good_q       <= good_d;
      timeout_q    <= timeout_d;
    end
  end

  assign pulse_valid_o = valid_q;
  assign pulse_good_o  = good_q;
  assign timeout_o     = timeout_q;

endmodule

// File: rtl/lvds_phase_sweep_ctrl.sv
// LVDS receiver PLL phase-sweep controller.
// Steps the PLL dynamic phase shift through every phase, grades each phase on the recovered
// HSYNC low width, picks the centre of the longest circular passing run and seeks to it.
// Optional macro LVDS_PHASE_MONITOR_EN: keep grading while locked; 4 consecutive bad pulses or
// a line timeout restart the sweep from the current phase.
//   clk_i, reset_i   : slow pixel clock, synchronous active-high reset (shared with PLL reset)
//   start_i          : re-sweep request, honoured in IDLE/LOCKED/ERROR
//   hsync_n_i        : recovered HSYNC, active low
//   phase_done_i     : PLL phase_done
//   phase_en_o, updn_o, cntsel_o : PLL dynamic phase-shift controls
//   cur_phase_o, best_phase_o, pass_map_o : sweep status
//   busy_o, locked_o, error_o             : controller status
module lvds_phase_sweep_ctrl
  import lvds_phase_pkg::*;
#(
  parameter int unsigned NUM_PHASES     = 8,
  parameter int unsigned SYN_LENGTH     = 22,
  parameter int unsigned DEVIATION      = SYN_LENGTH >> 3,
  parameter int unsigned LINES_PER_STEP = 16,
  parameter int unsigned SETTLE_CYCLES  = 192,
  parameter int unsigned LINE_TIMEOUT   = 4096,
  parameter int unsigned DONE_TIMEOUT   = 1024
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          hsync_n_i,
  input  logic                          phase_done_i,
  output logic                          phase_en_o,
  output logic                          updn_o,
  output logic [4:0]                    cntsel_o,
  output logic [$clog2(NUM_PHASES)-1:0] cur_phase_o,
  output logic [$clog2(NUM_PHASES)-1:0] best_phase_o,
  output logic [NUM_PHASES-1:0]         pass_map_o,
  output logic                          busy_o,
  output logic                          locked_o,
  output logic                          error_o
);

  localparam int unsigned PhW    = $clog2(NUM_PHASES);
  localparam int unsigned StW    = $clog2(NUM_PHASES + 1);
  localparam int unsigned LnW    = $clog2(LINES_PER_STEP + 1);
  localparam int unsigned CntMax = (SETTLE_CYCLES > DONE_TIMEOUT) ? SETTLE_CYCLES : DONE_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [9:0]  MinW   = 10'(SYN_LENGTH - DEVIATION);
  localparam logic [9:0]  MaxW   = 10'(SYN_LENGTH + DEVIATION);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [LnW-1:0]        lines_q, lines_d;
  logic                  all_good_q, all_good_d;
  logic [StW-1:0]        step_q, step_d;  // sweep: steps taken; seek: steps remaining
  logic                  seek_q, seek_d;
  logic [PhW-1:0]        cur_phase_q, cur_phase_d;
  logic [PhW-1:0]        best_phase_q, best_phase_d;
  logic [NUM_PHASES-1:0] pass_map_q, pass_map_d;
  logic                  restart;
  logic                  meter_en, meter_valid, meter_good, meter_timeout;
  eye_sel_t              sel;
  logic [StW-1:0]        seek_dist;

`ifdef LVDS_PHASE_MONITOR_EN
  logic [1:0] bad_q, bad_d;
  assign meter_en = (state_q == StMeasure) || (state_q == StLocked);
`else
  assign meter_en = (state_q == StMeasure);
`endif

  lvds_hsync_meter #(
    .LINE_TIMEOUT (LINE_TIMEOUT)
  ) u_meter (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .enable_i      (meter_en),
    .hsync_n_i     (hsync_n_i),
    .min_i         (MinW),
    .max_i         (MaxW),
    .pulse_valid_o (meter_valid),
    .pulse_good_o  (meter_good),
    .timeout_o     (meter_timeout)
  );

  always_comb begin
    sel       = eye_centre(32'(pass_map_q), NUM_PHASES);
    seek_dist = StW'((32'(sel.best) + NUM_PHASES - 32'(cur_phase_q)) % NUM_PHASES);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lines_d      = lines_q;
    all_good_d   = all_good_q;
    step_d       = step_q;
    seek_d       = seek_q;
    cur_phase_d  = cur_phase_q;
    best_phase_d = best_phase_q;
    pass_map_d   = pass_map_q;
    restart      = 1'b0;
`ifdef LVDS_PHASE_MONITOR_EN
    bad_d        = bad_q;
`endif
    unique case (state_q)
      StIdle, StError: begin
        if (start_i) restart = 1'b1;
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          state_d    = StMeasure;
          cnt_d      = '0;
          lines_d    = '0;
          all_good_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMeasure: begin
        if (meter_timeout) begin
          pass_map_d[cur_phase_q] = 1'b0;
          step_d  = step_q + StW'(1);
          cnt_d   = '0;
          state_d = StStepReq;
        end else if (meter_valid) begin
          lines_d    = lines_q + LnW'(1);
          all_good_d = all_good_q & meter_good;
          if (lines_q == LnW'(LINES_PER_STEP - 1)) begin
            pass_map_d[cur_phase_q] = all_good_q & meter_good;
            step_d  = step_q + StW'(1);
            cnt_d   = '0;
            state_d = StStepReq;
          end
        end
      end
      StStepReq: begin
        if (!phase_done_i) begin
          state_d = StStepAck;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(DONE_TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStepAck: begin
        if (phase_done_i) begin
          cur_phase_d = (cur_phase_q == PhW'(NUM_PHASES - 1)) ? '0 : cur_phase_q + PhW'(1);
          if (seek_q) step_d = step_q - StW'(1);
          state_d = StNext;
        end else if (cnt_q == CntW'(DONE_TIMEOUT - 1)) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StNext: begin
        cnt_d = '0;
        if (seek_q) begin
          state_d = (step_q == '0) ? StLocked : StStepReq;
        end else begin
          state_d = (step_q == StW'(NUM_PHASES)) ? StSelect : StSettle;
        end
      end
      StSelect: begin
        if (!sel.found) begin
          state_d = StError;
        end else begin
          best_phase_d = PhW'(sel.best);
          if (seek_dist == '0) begin
            state_d = StLocked;
          end else begin
            step_d  = seek_dist;
            seek_d  = 1'b1;
            state_d = StSeek;
          end
        end
      end
      StSeek: begin
        cnt_d   = '0;
        state_d = StStepReq;
      end
      StLocked: begin
        if (start_i) restart = 1'b1;
`ifdef LVDS_PHASE_MONITOR_EN
        if (meter_timeout) begin
          restart = 1'b1;
        end else if (meter_valid) begin
          if (meter_good)          bad_d   = '0;
          else if (bad_q == 2'd3)  restart = 1'b1;
          else                     bad_d   = bad_q + 2'd1;
        end
`endif
      end
      default: state_d = StError;
    endcase
    if (restart) begin
      state_d    = StSettle;
      cnt_d      = '0;
      step_d     = '0;
      seek_d     = 1'b0;
      pass_map_d = '0;
`ifdef LVDS_PHASE_MONITOR_EN
      bad_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StSettle;
      cnt_q        <= '0;
      lines_q      <= '0;
      all_good_q   <= 1'b1;
      step_q       <= '0;
      seek_q       <= 1'b0;
      cur_phase_q  <= '0;
      best_phase_q <= '0;
      pass_map_q   <= '0;
`ifdef LVDS_PHASE_MONITOR_EN
      bad_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lines_q      <= lines_d;
      all_good_q   <= all_good_d;
      step_q       <= step_d;
      seek_q       <= seek_d;
      cur_phase_q  <= cur_phase_d;
      best_phase_q <= best_phase_d;
      pass_map_q   <= pass_map_d;
`ifdef LVDS_PHASE_MONITOR_EN
      bad_q        <= bad_d;
`endif
    end
  end

  assign phase_en_o   = (state_q == StStepReq);
  assign updn_o       = 1'b1;
  assign cntsel_o     = CNTSEL_OUT0;
  assign cur_phase_o  = cur_phase_q;
  assign best_phase_o = best_phase_q;
  assign pass_map_o   = pass_map_q;
  assign locked_o     = (state_q == StLocked);
  assign error_o      = (state_q == StError);
  assign busy_o       = !((state_q == StIdle) || (state_q == StLocked) || (state_q == StError));

endmodule

// File: tb/tb_lvds_phase_sweep_ctrl.sv
// Testbench for lvds_phase_sweep_ctrl: PLL phase-step model plus HSYNC generator whose pulse
// width depends on the modelled physical PLL phase. Expected sweep outcomes are queued when a
// scenario is set up and compared once the controller goes idle.
module tb_lvds_phase_sweep_ctrl;

  localparam int unsigned NPh    = 8;
  localparam int unsigned LineTo = 1024;
  localparam int unsigned DoneTo = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hsync_n;
  logic       phase_done;
  logic       phase_en, updn, busy, locked, err;
  logic [4:0] cntsel;
  logic [2:0] cur_phase, best_phase;
  logic [7:0] pass_map;

  lvds_phase_sweep_ctrl #(
    .NUM_PHASES   (NPh),
    .LINE_TIMEOUT (LineTo),
    .DONE_TIMEOUT (DoneTo)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .start_i      (start),
    .hsync_n_i    (hsync_n),
    .phase_done_i (phase_done),
    .phase_en_o   (phase_en),
    .updn_o       (updn),
    .cntsel_o     (cntsel),
    .cur_phase_o  (cur_phase),
    .best_phase_o (best_phase),
    .pass_map_o   (pass_map),
    .busy_o       (busy),
    .locked_o     (locked),
    .error_o      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned hs_width [NPh];
  logic        hs_none    = 1'b0;
  logic        done_stuck = 1'b0;
  int unsigned pll_phase  = 0;
  int unsigned pll_steps  = 0;

  typedef struct packed {
    logic [7:0] map;
    logic [2:0] best;
    logic [2:0] cur;
    logic       locked;
    logic       err;
    logic [7:0] steps;
  } exp_t;
  exp_t sb_q[$];

  // PLL dynamic phase-shift model: phase_done falls after phase_en, rises 3 cycles later.
  initial begin
    int unsigned pll_cnt;
    pll_cnt    = 0;
    phase_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        phase_done = 1'b1;
        pll_phase  = 0;
        pll_cnt    = 0;
      end else if (done_stuck) begin
        phase_done = 1'b1;
        pll_cnt    = 0;
      end else if (pll_cnt == 0) begin
        if (phase_en) begin
          phase_done = 1'b0;
          pll_cnt    = 1;
        end
      end else if (pll_cnt == 3) begin
        phase_done = 1'b1;
        pll_cnt    = 0;
        pll_phase  = (pll_phase + 1) % NPh;
        pll_steps++;
      end else begin
        pll_cnt++;
      end
    end
  end

  // HSYNC source: low for hs_width[physical phase] cycles, then high for 40.
  initial begin
    int unsigned hs_cnt;
    int unsigned hs_w;
    hs_cnt  = 0;
    hs_w    = 22;
    hsync_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hs_none || rst) begin
        hsync_n = 1'b1;
        hs_cnt  = 0;
      end else begin
        if (hs_cnt == 0) hs_w = hs_width[pll_phase];
        hsync_n = (hs_cnt >= hs_w);
        hs_cnt  = (hs_cnt + 1 == hs_w + 40) ? 0 : hs_cnt + 1;
      end
    end
  end

  task automatic set_widths(input logic [7:0] good_mask);
    for (int i = 0; i < NPh; i++) hs_width[i] = good_mask[i] ? 22 : 30;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait for the controller to go idle, then compare against the oldest queued expectation.
  task automatic drain_sweep(input string name, input int unsigned base);
    exp_t        e;
    int unsigned n;
    n = 0;
    while (busy && n < 40000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
    e = sb_q.pop_front();
    total++;
    if (pass_map !== e.map) begin
      bad++;
      $display("FAIL %s_pass_map: got %h required %h", name, pass_map, e.map);
    end
    total++;
    if (best_phase !== e.best) begin
      bad++;
      $display("FAIL %s_best: got %0d required %0d", name, best_phase, e.best);
    end
    total++;
    if (cur_phase !== e.cur || pll_phase != 32'(e.cur)) begin
      bad++;
      $display("FAIL %s_cur: got dut=%0d pll=%0d required %0d", name, cur_phase, pll_phase,
               e.cur);
    end
    total++;
    if ({locked, err} !== {e.locked, e.err}) begin
      bad++;
      $display("FAIL %s_status: got locked=%0b err=%0b required locked=%0b err=%0b", name,
               locked, err, e.locked, e.err);
    end
    total++;
    if (8'(pll_steps - base) !== e.steps) begin
      bad++;
      $display("FAIL %s_steps: got %0d required %0d", name, pll_steps - base, e.steps);
    end
  endtask

  task automatic test_reset();
    set_widths(8'hFF);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({phase_en, locked, err, busy, cur_phase, best_phase, pass_map} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: got en=%0b lk=%0b er=%0b bz=%0b cur=%0d best=%0d map=%h",
               phase_en, locked, err, busy, cur_phase, best_phase, pass_map);
    end
    total++;
    if ({updn, cntsel} !== {1'b1, 5'b00001}) begin
      bad++;
      $display("FAIL pll_ctrl_const: got updn=%0b cntsel=%b required 1 00001", updn, cntsel);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_clean_sweep();
    int unsigned base;
    base = pll_steps;
    sb_q.push_back('{map: 8'hFF, best: 3'd3, cur: 3'd3, locked: 1'b1, err: 1'b0, steps: 8'd11});
    drain_sweep("clean", base);
  endtask

  task automatic test_narrow_eye();
    int unsigned base;
    set_widths(8'hC3);
    pulse_reset();
    base = pll_steps;
    sb_q.push_back('{map: 8'hC3, best: 3'd7, cur: 3'd7, locked: 1'b1, err: 1'b0, steps: 8'd15});
    drain_sweep("narrow", base);
  endtask

  task automatic test_start_tie();
    int unsigned base;
    set_widths(8'h66);
    base = pll_steps;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({locked, busy, pass_map} !== {1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL start_clear: got locked=%0b busy=%0b map=%h required 0 1 00", locked, busy,
               pass_map);
    end
    sb_q.push_back('{map: 8'h66, best: 3'd1, cur: 3'd1, locked: 1'b1, err: 1'b0, steps: 8'd10});
    drain_sweep("tie", base);
  endtask

  task automatic test_locked_bad_lines();
    int unsigned n;
    set_widths(8'h00);
    n = 0;
`ifdef LVDS_PHASE_MONITOR_EN
    while (locked && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if ({locked, busy} !== 2'b01) begin
      bad++;
      $display("FAIL monitor_resweep: got locked=%0b busy=%0b required 0 1", locked, busy);
    end
`else
    while (n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if ({locked, busy} !== 2'b10) begin
      bad++;
      $display("FAIL locked_hold: got locked=%0b busy=%0b required 1 0", locked, busy);
    end
`endif
  endtask

  task automatic test_no_hsync();
    int unsigned base;
    hs_none = 1'b1;
    pulse_reset();
    base = pll_steps;
    sb_q.push_back('{map: 8'h00, best: 3'd0, cur: 3'd0, locked: 1'b0, err: 1'b1, steps: 8'd8});
    drain_sweep("no_hsync", base);
    hs_none = 1'b0;
  endtask

  task automatic test_done_stuck();
    int unsigned n;
    int unsigned high;
    set_widths(8'hFF);
    done_stuck = 1'b1;
    pulse_reset();
    n = 0;
    while (!phase_en && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    high = 0;
    while (phase_en && high < 3000) begin
      @(posedge clk); #1;
      high++;
    end
    total++;
    if (high != DoneTo) begin
      bad++;
      $display("FAIL stuck_en_cycles: got %0d required %0d", high, DoneTo);
    end
    total++;
    if ({err, phase_en, busy, locked} !== 4'b1000) begin
      bad++;
      $display("FAIL stuck_error: got err=%0b en=%0b busy=%0b locked=%0b required 1 0 0 0", err,
               phase_en, busy, locked);
    end
    done_stuck = 1'b0;
  endtask

  task automatic test_reset_mid_step();
    int unsigned n;
    pulse_reset();
    n = 0;
    while (!(phase_en && cur_phase == 3'd1) && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (phase_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_step_reach: phase_en=%0b after %0d cycles, required 1", phase_en, n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({phase_en, cur_phase, busy} !== {1'b0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_step_reset: got en=%0b cur=%0d busy=%0b required 0 0 1", phase_en,
               cur_phase, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_narrow_eye();
    test_start_tie();
    test_locked_bad_lines();
    test_no_hsync();
    test_done_stuck();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lvds_phase_sweep_ctrl.md
Name: lvds_phase_sweep_ctrl

Overview:
- Sequences the receiver PLL dynamic phase-shift port so the deserializer samples at the centre of the data eye.
- Steps through every PLL output phase and grades each one by checking the recovered HSYNC low-pulse width against the nominal length.
- Builds a pass map, selects the centre of the longest circular passing run, steps the PLL to that phase, then reports lock.
- Sits between the PLL (phase_en/updn/cntsel/phase_done) and the slow-clock receiver outputs, replacing a blind shift-until-sync loop.

Parameters:
- NUM_PHASES, 8: phase steps per full PLL revolution (2..32).
- SYN_LENGTH, 22: nominal HSYNC low width in slow-clock cycles.
- DEVIATION, SYN_LENGTH>>3: allowed +/- error on the width.
- LINES_PER_STEP, 16: HSYNC pulses graded per phase.
- SETTLE_CYCLES, 192: wait after each phase step before measuring.
- LINE_TIMEOUT, 4096: maximum cycles between completed pulses.
- DONE_TIMEOUT, 1024: maximum cycles for each phase_done edge.

Ports:
- clk_i  in  1  slow pixel clock.
- reset_i  in  1  synchronous, active-high.
- start_i  in  1  pulse; requests a re-sweep.
- hsync_n_i  in  1  recovered HSYNC, active low.
- phase_done_i  in  1  PLL phase_done.
- phase_en_o  out  1  PLL phase_en.
- updn_o  out  1  constant 1 (step up).
- cntsel_o  out  5  constant 5'b00001.
- cur_phase_o  out  clog2(NUM_PHASES)  current phase index.
- best_phase_o  out  clog2(NUM_PHASES)  selected phase.
- pass_map_o  out  NUM_PHASES  bit i = phase i passed.
- busy_o  out  1  sweep or seek in progress.
- locked_o  out  1  eye centre reached.
- error_o  out  1  no passing phase, or handshake timeout.

Behaviour:
- Interface (already decided): one clock, clk_i; reset_i is synchronous and active-high.
- Reset state:
  - FSM enters SETTLE (automatic sweep after reset).
  - phase_en_o, locked_o and error_o are 0; busy_o is 1.
  - cur_phase_o, best_phase_o and pass_map_o are 0.
  - reset_i is shared with the PLL reset, so physical phase index 0 coincides with cur_phase 0.
- States: IDLE, SETTLE, MEASURE, STEP_REQ, STEP_ACK, NEXT, SELECT, SEEK, LOCKED, ERROR.
- SETTLE: count SETTLE_CYCLES, then go to MEASURE.
- MEASURE:
  - The meter counts hsync_n_i low cycles, saturating at 1023; a pulse completes on the rising edge.
  - A pulse is good if SYN_LENGTH-DEVIATION <= width <= SYN_LENGTH+DEVIATION.
  - After LINES_PER_STEP completed pulses: pass_map[cur_phase] = all good.
  - If LINE_TIMEOUT cycles pass without a completed pulse, the phase fails immediately.
  - The step counter is incremented, then go to STEP_REQ.
- Phase-step handshake:
  - STEP_REQ: phase_en_o=1 until phase_done_i is sampled 0.
  - STEP_ACK: phase_en_o=0, wait for phase_done_i=1.
  - Each wait has its own DONE_TIMEOUT; on expiry go to ERROR with error_o=1.
  - On completion, cur_phase increments mod NUM_PHASES.
- NEXT:
  - Sweep (NUM_PHASES steps, ending at the start phase): go to SELECT when the step count reaches NUM_PHASES, else SETTLE.
  - Seek: go to LOCKED when the remaining count reaches 0, else STEP_REQ.
- SELECT:
  - Find the longest circular run of 1s in pass_map; ties go to the run with the lowest start index.
  - best = (start + (len-1)/2) mod NUM_PHASES. All-pass gives start 0, best (NUM_PHASES-1)/2.
  - Zero passes: go to ERROR with error_o=1.
  - Otherwise seek steps = (best - cur_phase) mod NUM_PHASES; if 0 go directly to LOCKED.
  - SELECT takes at most NUM_PHASES+2 cycles.
- SEEK: loop STEP_REQ -> STEP_ACK -> NEXT until the remaining count is 0.
- LOCKED: locked_o=1, busy_o=0, pass_map_o and best_phase_o held stable.
- ERROR: error_o=1, busy_o=0, phase_en_o=0.
- start_i:
  - Honoured only in IDLE, LOCKED and ERROR.
  - Clears locked_o, error_o and pass_map, then goes to SETTLE; the sweep starts from the current cur_phase.
  - Ignored while busy_o=1.
- phase_en_o is never asserted outside STEP_REQ.
- A reset mid-handshake drops phase_en_o in the next cycle.

Optional Feature:
- Macro: LVDS_PHASE_MONITOR_EN.
- Defined: in LOCKED the meter keeps grading pulses. 4 consecutive bad pulses, or a LINE_TIMEOUT, clear locked_o and start an automatic re-sweep from cur_phase, as if start_i had been pulsed.
- Undefined: LOCKED holds until start_i or reset_i.

Decomposition:
- Package lvds_phase_pkg:
  - state enum;
  - CNTSEL_OUT0 = 5'b00001;
  - width-window check function;
  - circular longest-run/centre function (parameterised by NUM_PHASES via a fixed maximum width of 32).
- Sub-module lvds_hsync_meter:
  - inputs: hsync_n_i, enable, min/max;
  - outputs: pulse_valid and pulse_good strobes, plus timeout strobe.

Test Plan:
- Clean 22-cycle HSYNC at all phases, PLL model answers phase_done after 3 cycles:
  - 8 sweep steps, pass_map=8'hFF, best=3;
  - 3 seek steps, then locked_o=1, cur_phase=3.
- Pass only at phases 6,7,0,1 (others width 30):
  - pass_map=8'hC3, best=7, 7 seek steps, locked_o=1.
- Two equal runs {1,2} and {5,6}: best=1 (lowest start).
- No HSYNC edges: every phase times out, pass_map=0, error_o=1, locked_o=0, busy_o=0.
- phase_done_i stuck at 1: ERROR after DONE_TIMEOUT cycles, phase_en_o=0 the following cycle.
- reset_i asserted during STEP_REQ: next cycle phase_en_o=0, cur_phase=0, busy_o=1.
- With LVDS_PHASE_MONITOR_EN, 4 bad lines while locked: locked_o drops, busy_o=1, re-sweep starts.
